multicycle_controller: RTL
==========================

# multicycle_controller

Control FSM for the multicycle RV32I core variant: sequences a shared-ALU, shared-memory datapath through Fetch/Decode/Execute/Memory/Writeback one step per clock. Accepts lw, sw, R-type, I-type ALU, beq and jal, and stretches memory states until a ready handshake. It also decodes ALU operations, sticky-flags illegal opcodes and exports its state for debug.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- instr  in  32  contents of instruction register; uses op=[6:0], funct3=[14:12], funct7b5=[30]
- zero  in  1  ALU zero flag
- memready  in  1  memory has completed the current access this cycle
- pcwrite  out  1  PC register enable
- adrsrc  out  1  memory address: 0=PC, 1=Result
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction/OldPC register enable
- regwrite  out  1  register file write
- resultsrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- alusrca  out  2  00=PC, 01=OldPC, 10=rs1 data
- alusrcb  out  2  00=rs2 data, 01=immediate, 10=constant 4
- immsrc  out  2  00=I, 01=S, 10=B, 11=J (pure function of op)
- alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal  out  1  sticky illegal-opcode flag
- state  out  4  current state encoding

## Operation
- States (encoding 0..11): FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, ALUWB, EXECI, JAL, BEQ, TRAP.
- All unlisted strobes 0 and selects 00; aluop 00 (add) unless noted.
- FETCH: adrsrc=0, alusrca=00, alusrcb=10, resultsrc=10; irwrite=pcwrite=memready. Stay while !memready; else go to DECODE.
- DECODE: alusrca=01, alusrcb=01 (branch target into ALUOut). Next state by op: 0000011/0100011→MEMADR, 0110011→EXECR, 0010011→EXECI, 1101111→JAL, 1100011→BEQ, other→TRAP.
- MEMADR: alusrca=10, alusrcb=01. Next state: MEMREAD if op[5]=0, MEMWRITE if op[5]=1.
- MEMREAD: adrsrc=1, resultsrc=00. Hold until memready, then go to MEMWB.
- MEMWB: resultsrc=01, regwrite=1. Next state FETCH.
- MEMWRITE: adrsrc=1, resultsrc=00, memwrite=1 held until memready. Then go to FETCH.
- EXECR: alusrca=10, alusrcb=00, aluop 10. EXECI: alusrca=10, alusrcb=01, aluop 10. Both go to ALUWB.
- ALUWB: resultsrc=00, regwrite=1. Next state FETCH.
- JAL: alusrca=01, alusrcb=10, resultsrc=00, pcwrite=1. Next state ALUWB (writes PC+4).
- BEQ: alusrca=10, alusrcb=00, aluop 01, resultsrc=00, pcwrite=zero. Next state FETCH.
- TRAP: all strobes 0, illegal=1. Remains in TRAP until reset.
- ALU decode:
  - aluop 00→add; 01→sub.
  - aluop 10 decodes {funct3, funct7b5&op[5]}: 0000 add, 0001 sub, 010x slt, 110x or, 111x and, else add.

## Timing
- Moore outputs, except pcwrite/irwrite in FETCH (gated by memready), pcwrite in BEQ (gated by zero), and memwrite's completion (observed via memready).
- Latency with memready tied 1: lw 5, sw 4, R/I 4, jal 4, beq 3 cycles. Each cycle memready is low in a memory state adds one.
- Reset:
  - Next edge: state=FETCH, illegal=0.
  - While reset=1, all write strobes (pcwrite, irwrite, memwrite, regwrite) forced 0.
  - Reset mid-instruction abandons it with no further writes.
- memready is ignored outside FETCH/MEMREAD/MEMWRITE.

## Configuration
- MC_BNE_EN defined:
  - funct3=001 in BEQ state uses pcwrite=!zero (bne).
  - funct3 other than 000/001 with op 1100011 goes to TRAP.
- MC_BNE_EN undefined: every op 1100011 is treated as beq regardless of funct3.

## Structure
- Shared package mc_pkg: state enum, opcode constants, aluop/alucontrol/resultsrc/alusrc encodings.
- One sub-module, mc_alu_decoder: combinational aluop+funct→alucontrol.

## Test plan
- add x3,x1,x2 (0x002081B3), memready=1 → state sequence 0,1,6,7,0. alucontrol=000 in EXECR. regwrite=1 only in ALUWB.
- lw x5,4(x0) (0x00402283), memready low 2 cycles in MEMREAD → MEMREAD held 3 cycles, adrsrc=1. Then MEMWB with resultsrc=01, regwrite=1. Total 7 cycles.
- sw x5,8(x0) (0x00502423) → immsrc=01. memwrite=1 exactly in MEMWRITE. No regwrite at any point.
- beq x0,x0,8 (0x00000463): with zero=1 → pcwrite=1 in BEQ, alucontrol=001. With zero=0 → pcwrite=0.
- jal x1,8 (0x008000EF) → immsrc=11. pcwrite in JAL, then regwrite in ALUWB.
- Opcode 0x7F → TRAP, illegal=1 held 10 cycles. Reset → FETCH, illegal=0.
- With MC_BNE_EN, 0x00001463 and zero=0 → pcwrite=1 in BEQ.

Source files
------------

// File: rtl/mc_pkg.sv
// ============================================================================
// mc_pkg : shared encodings for the multicycle RV32I control FSM
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package mc_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXECI    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format depends only on the opcode, never on FSM state.
  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:  imm_sel = IMM_S;
      OP_BRANCH: imm_sel = IMM_B;
      OP_JAL:    imm_sel = IMM_J;
      default:   imm_sel = IMM_I;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_alu_decoder.sv
// ============================================================================
// mc_alu_decoder : combinational aluop + funct fields -> alucontrol
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alucontrol
);

  // funct7b5 only selects sub for R-type; I-type addi with imm[10] set stays add.
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        casez ({funct3, funct7b5 & op5})
          4'b0001: alucontrol = ALU_SUB;
          4'b010?: alucontrol = ALU_SLT;
          4'b110?: alucontrol = ALU_OR;
          4'b111?: alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// multicycle_controller : Fetch/Decode/Execute/Memory/Writeback control FSM
// Optional build macro MC_BNE_EN adds bne and traps other branch funct3 codes.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module multicycle_controller
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        memready,
  output logic        pcwrite,
  output logic        adrsrc,
  output logic        memwrite,
  output logic        irwrite,
  output logic        regwrite,
  output logic [1:0]  resultsrc,
  output logic [1:0]  alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  immsrc,
  output logic [2:0]  alucontrol,
  output logic        illegal,
  output logic [3:0]  state
);

  logic [6:0] op;
  logic [2:0] funct3;
  logic [3:0] state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [1:0] aluop;
  logic       branch_taken;
  logic       unused_instr_bits;

  assign op     = instr[6:0];
  assign funct3 = instr[14:12];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

`ifdef MC_BNE_EN
  assign branch_taken = (funct3 == 3'b001) ? ~zero : zero;
`else
  assign branch_taken = zero;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (memready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
`ifdef MC_BNE_EN
          OP_BRANCH:         state_d = (funct3[2:1] == 2'b00) ? S_BEQ : S_TRAP;
`else
          OP_BRANCH:         state_d = S_BEQ;
`endif
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (memready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (memready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
  end

  assign illegal_d = illegal_q | (state_d == S_TRAP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    pcwrite   = 1'b0;
    adrsrc    = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    resultsrc = RES_ALUOUT;
    alusrca   = SRCA_PC;
    alusrcb   = SRCB_RS2;
    aluop     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALURESULT;
        irwrite   = memready;
        pcwrite   = memready;
      end
      S_DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
      end
      S_MEMADR: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
      end
      S_MEMREAD: adrsrc = 1'b1;
      S_MEMWB: begin
        resultsrc = RES_DATA;
        regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECR: begin
        alusrca = SRCA_RS1;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: regwrite = 1'b1;
      S_JAL: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_FOUR;
        pcwrite = 1'b1;
      end
      S_BEQ: begin
        alusrca = SRCA_RS1;
        aluop   = ALUOP_SUB;
        pcwrite = branch_taken;
      end
      default: ;
    endcase
    // A reset cycle must never commit architectural state.
    if (reset) begin
      pcwrite  = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
    end
  end

  mc_alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7b5   (instr[30]),
    .op5        (op[5]),
    .alucontrol (alucontrol)
  );

  assign immsrc  = imm_sel(op);
  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

`default_nettype wire
